// File: rtl/instr_fetch_if.sv
// Instruction-memory request/valid bus between the fetch stage and the memory.
// The master side issues requests; the slave side returns one data pulse per request.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding imem request per captured PC, presents the word to decode,
// holds it across stalls, drops redirect-killed responses, and substitutes a NOP on errors.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_addr_i,
  input  logic                 redirect_i,
  input  logic                 stall_i,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr_out_o,
  output logic [31:0]          instr_pc_o,
  output logic                 instr_valid_o,
  output logic                 misaligned_o,
  output logic                 fetch_err_o
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       instr_out_q;
  logic [31:0]       instr_pc_q;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic              misaligned_q;
  logic              fetch_err_q;
  logic              kill_q;
  logic [TimerW-1:0] timer_q;
  logic [TimerW-1:0] timer_d;
  logic              capture;
  logic              pc_unaligned;

  assign pc_unaligned = |pc_addr_i[1:0];
  assign timer_d      = (timer_q == {TimerW{1'b1}}) ? timer_q : timer_q + TimerW'(1);

  // Every point where a fresh PC is taken: after reset, after a dropped
  // (killed) response, and when decode consumes the presented word.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      IDLE:    capture = 1'b1;
      FETCH:   capture = imem.imem_valid && (kill_q || redirect_i);
      DONE:    capture = !stall_i;
      default: capture = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      instr_out_q   <= NOP_INSTR;
      instr_pc_q    <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
      kill_q        <= 1'b0;
      timer_q       <= '0;
    end else if (capture) begin
      fetch_pc_q  <= pc_addr_i;
      timer_q     <= '0;
      kill_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      if (pc_unaligned) begin
        // Misaligned PC never reaches memory; decode gets a flagged NOP instead.
        state_q       <= DONE;
        imem_req_q    <= 1'b0;
        instr_out_q   <= NOP_INSTR;
        instr_pc_q    <= pc_addr_i;
        instr_valid_q <= 1'b1;
        misaligned_q  <= 1'b1;
      end else begin
        state_q       <= FETCH;
        imem_req_q    <= 1'b1;
        instr_valid_q <= 1'b0;
        misaligned_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_valid) begin
            state_q       <= DONE;
            imem_req_q    <= 1'b0;
            instr_out_q   <= imem.imem_rdata;
            instr_pc_q    <= fetch_pc_q;
            instr_valid_q <= 1'b1;
          end else if (timer_q == TimerLast) begin
            // Memory never answered: give up and hand decode a flagged NOP.
            state_q       <= DONE;
            imem_req_q    <= 1'b0;
            instr_out_q   <= NOP_INSTR;
            instr_pc_q    <= fetch_pc_q;
            instr_valid_q <= 1'b1;
            fetch_err_q   <= 1'b1;
            kill_q        <= 1'b0;
          end else begin
            timer_q <= timer_d;
            if (redirect_i) begin
              kill_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (redirect_i) begin
            instr_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = fetch_pc_q;
  assign instr_out_o    = instr_out_q;
  assign instr_pc_o     = instr_pc_q;
  assign instr_valid_o  = instr_valid_q;
  assign misaligned_o   = misaligned_q;
  assign fetch_err_o    = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a transaction-level model:
// each fetch's expected presentation is derived from the scenario chosen by the bench.
module tb_instr_fetch;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_addr = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b1;
  logic [31:0] instr_out, instr_pc;
  logic        instr_valid, misaligned, fetch_err;

  int checks = 0;
  int fails  = 0;

  // Model of what decode should currently see.
  logic [31:0] exp_instr, exp_pc;
  logic        exp_valid, exp_mis, exp_err;

  instr_fetch_if bus ();

  instr_fetch #(.TIMEOUT_CYCLES(TIMEOUT), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_addr_i    (pc_addr),
    .redirect_i   (redirect),
    .stall_i      (stall),
    .imem         (bus),
    .instr_out_o  (instr_out),
    .instr_pc_o   (instr_pc),
    .instr_valid_o(instr_valid),
    .misaligned_o (misaligned),
    .fetch_err_o  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_presented(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'(exp_valid));
    check({tag, ".instr"}, instr_out, exp_instr);
    check({tag, ".pc"}, instr_pc, exp_pc);
    check({tag, ".mis"}, 32'(misaligned), 32'(exp_mis));
    check({tag, ".err"}, 32'(fetch_err), 32'(exp_err));
    check({tag, ".req"}, 32'(bus.imem_req), 32'd0);
  endtask

  task automatic check_fetching(input string tag, input logic [31:0] addr);
    check({tag, ".req"}, 32'(bus.imem_req), 32'd1);
    check({tag, ".addr"}, bus.imem_addr, addr);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 4) == 0) v[1:0] = 2'($urandom_range(1, 3));
    else v[1:0] = 2'b00;
    return v;
  endfunction

  // Expected view right after a PC has been captured.
  task automatic after_capture(input logic [31:0] pc);
    logic [1:0] lo;
    lo = pc[1:0];
    if (lo != 2'b00) begin
      exp_instr = NOP; exp_pc = pc; exp_valid = 1'b1; exp_mis = 1'b1; exp_err = 1'b0;
      check_presented("misalign");
    end else begin
      check_fetching("request", pc);
    end
  endtask

  // Memory answers after lat cycles of request; pc_addr wanders meanwhile.
  task automatic serve(input logic [31:0] pc, input int lat, input logic [31:0] data);
    for (int c = 1; c <= lat; c++) begin
      pc_addr = $urandom;
      bus.imem_rdata = $urandom;
      if (c == lat) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = data;
      end
      tick();
      bus.imem_valid = 1'b0;
      if (c < lat) check_fetching("wait", pc);
    end
    exp_instr = data; exp_pc = pc; exp_valid = 1'b1; exp_mis = 1'b0; exp_err = 1'b0;
    check_presented("resp");
    $display("fetch pc=%h lat=%0d data=%h", pc, lat, data);
  endtask

  task automatic timeout_fetch(input logic [31:0] pc);
    for (int c = 1; c <= TIMEOUT; c++) begin
      pc_addr = $urandom;
      tick();
      if (c < TIMEOUT) check_fetching("tmo_wait", pc);
    end
    exp_instr = NOP; exp_pc = pc; exp_valid = 1'b1; exp_mis = 1'b0; exp_err = 1'b1;
    check_presented("timeout");
    bus.imem_valid = 1'b1;
    bus.imem_rdata = $urandom;
    tick();
    bus.imem_valid = 1'b0;
    check_presented("late_valid");
    $display("timeout pc=%h", pc);
  endtask

  // Redirect at FETCH cycle r (1..lat); the response at cycle lat must be dropped.
  task automatic redirect_fetch(input logic [31:0] pc, input int lat, input int r,
                                input logic [31:0] pc2, input int lat2, input logic [31:0] data2);
    pc_addr = pc2;
    for (int c = 1; c <= lat; c++) begin
      redirect = (c == r);
      if (c == lat) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end
      tick();
      bus.imem_valid = 1'b0;
      redirect = 1'b0;
      if (c < lat) check_fetching("kill_wait", pc);
    end
    $display("redirect pc=%h at=%0d new_pc=%h", pc, r, pc2);
    after_capture(pc2);
    if (pc2[1:0] == 2'b00) serve(pc2, lat2, data2);
  endtask

  task automatic stall_phase(input int n, input bit allow_redirect);
    for (int i = 0; i < n; i++) begin
      pc_addr = $urandom;
      redirect = allow_redirect && ($urandom_range(0, 3) == 0);
      bus.imem_valid = ($urandom_range(0, 3) == 0);
      bus.imem_rdata = $urandom;
      tick();
      if (redirect) exp_valid = 1'b0;
      redirect = 1'b0;
      bus.imem_valid = 1'b0;
      check_presented("stall");
    end
  endtask

  task automatic consume(input logic [31:0] next_pc);
    pc_addr = next_pc;
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    stall = 1'b1;
    after_capture(next_pc);
  endtask

  initial begin
    logic [31:0] cur_pc, pc2;
    int mode;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;

    // Reset values
    #1 rst = 1'b0;
    tick();
    tick();
    check("rst.req", 32'(bus.imem_req), 32'd0);
    check("rst.addr", bus.imem_addr, 32'd0);
    check("rst.instr", instr_out, NOP);
    check("rst.pc", instr_pc, 32'd0);
    check("rst.valid", 32'(instr_valid), 32'd0);
    check("rst.mis", 32'(misaligned), 32'd0);
    check("rst.err", 32'(fetch_err), 32'd0);

    // Basic fetch at 0 with a 2-cycle memory latency
    pc_addr = 32'h0;
    rst = 1'b1;
    tick();
    after_capture(32'h0);
    serve(32'h0, 2, 32'h0050_0093);

    // Stall holds the word while pc_addr moves on
    for (int i = 0; i < 5; i++) begin
      pc_addr = 32'h8;
      tick();
      check_presented("hold");
    end
    consume(32'h8);
    serve(32'h8, 1, 32'h0010_0513);

    // Redirect kills the in-flight fetch of 0x4
    consume(32'h4);
    redirect_fetch(32'h4, 3, 1, 32'h40, 2, 32'h00A0_0113);

    // Misaligned capture
    consume(32'h6);
    stall_phase(2, 1'b0);

    // Timeout
    consume(32'h100);
    timeout_fetch(32'h100);

    // Randomized transactions
    cur_pc = 32'h100;
    for (int t = 0; t < 40; t++) begin
      stall_phase($urandom_range(0, 3), 1'b1);
      cur_pc = rand_pc();
      consume(cur_pc);
      if (cur_pc[1:0] == 2'b00) begin
        mode = $urandom_range(0, 7);
        if (mode == 7) begin
          timeout_fetch(cur_pc);
        end else if (mode >= 5) begin
          int lat;
          lat = $urandom_range(1, 6);
          pc2 = rand_pc();
          redirect_fetch(cur_pc, lat, $urandom_range(1, lat), pc2, $urandom_range(1, 5), $urandom);
        end else begin
          serve(cur_pc, $urandom_range(1, 8), $urandom);
        end
      end else begin
        $display("misaligned pc=%h", cur_pc);
      end
    end

    // Reset mid-FETCH drops the request without waiting for a clock
    stall_phase(1, 1'b0);
    consume(32'h200);
    tick();
    check_fetching("pre_rst", 32'h200);
    #2 rst = 1'b0;
    #1;
    check("arst.req", 32'(bus.imem_req), 32'd0);
    check("arst.valid", 32'(instr_valid), 32'd0);
    tick();
    check("arst.instr", instr_out, NOP);
    check("arst.addr", bus.imem_addr, 32'd0);
    $display("async reset during fetch");

    // Reset while a word is presented
    pc_addr = 32'h300;
    rst = 1'b1;
    tick();
    after_capture(32'h300);
    serve(32'h300, 1, 32'h1234_5678);
    #2 rst = 1'b0;
    #1;
    check("arst2.valid", 32'(instr_valid), 32'd0);
    check("arst2.pc", instr_pc, 32'd0);
    $display("async reset during present");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
